// File: rtl/pad_attr_writer_if.sv
// pad_attr_writer_if: request/response/shadow bundle between the register side and the pad ring
interface pad_attr_writer_if #(
  parameter int NumPads = 8,
  parameter int AttrDw  = 32,
  parameter int PadW    = NumPads > 1 ? $clog2(NumPads) : 1
);
  logic [AttrDw-1:0]         warl_mask_i;
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [PadW-1:0]           req_pad_i;
  logic [AttrDw-1:0]         req_attr_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [AttrDw-1:0]         rsp_attr_o;
  logic                      rsp_err_o;
  logic [NumPads*AttrDw-1:0] attr_o;
  logic [NumPads-1:0]        attr_update_o;
  modport slave (
    input  warl_mask_i, req_valid_i, req_pad_i, req_attr_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_attr_o, rsp_err_o, attr_o, attr_update_o
  );
  modport master (
    output warl_mask_i, req_valid_i, req_pad_i, req_attr_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_attr_o, rsp_err_o, attr_o, attr_update_o
  );
endinterface

// File: rtl/pad_attr_writer.sv
// pad_attr_writer: masks attribute writes with the WARL mask, commits them per pad, then responds
module pad_attr_writer #(
  parameter int NumPads      = 8,
  parameter int AttrDw       = 32,
  parameter int SettleCycles = 2,
  parameter int PadType      = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  pad_attr_writer_if.slave bus
);
  localparam int PadW    = NumPads > 1 ? $clog2(NumPads) : 1;
  localparam int CntW    = $clog2(SettleCycles + 1) > 0 ? $clog2(SettleCycles + 1) : 1;
  localparam int CntLoad = SettleCycles > 0 ? SettleCycles - 1 : 0;
  if (NumPads < 1 || PadType < 0) begin : g_bad_params
    $error("pad_attr_writer: invalid parameters");
  end
  typedef enum logic [1:0] {IDLE, APPLY, SETTLE, RESP} state_t;
  state_t            state, state_n;
  logic              rdy_q, err_q, accept, pad_bad;
  logic [PadW-1:0]   pad_q;
  logic [AttrDw-1:0] attr_in_q, rsp_q, new_val;
  logic [CntW-1:0]   cnt_q;
  logic [NumPads-1:0] upd;
  logic [AttrDw-1:0] attr_q [NumPads];
  assign accept  = bus.req_valid_i & rdy_q;
  assign pad_bad = 32'(bus.req_pad_i) >= 32'(NumPads);
  assign new_val = attr_in_q & bus.warl_mask_i;
  assign upd     = (state == APPLY) ? NumPads'(1) << pad_q : '0;
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = pad_bad ? RESP : APPLY;
    if (state == APPLY) state_n = SettleCycles == 0 ? RESP : SETTLE;
    if (state == SETTLE && cnt_q == '0) state_n = RESP;
    if (state == RESP && bus.rsp_ready_i) state_n = IDLE;
  end
  // ready is registered from next-state so it stays low for the first cycle after reset
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state     <= IDLE;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      pad_q     <= '0;
      attr_in_q <= '0;
      rsp_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state <= state_n;
      rdy_q <= state_n == IDLE;
      if (accept) begin
        pad_q     <= bus.req_pad_i;
        attr_in_q <= bus.req_attr_i;
        err_q     <= pad_bad;
      end
      if (state == APPLY) begin
        rsp_q <= new_val;
        cnt_q <= CntW'(CntLoad);
      end
      if (state == SETTLE && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  for (genvar k = 0; k < NumPads; k++) begin : g_pad
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) attr_q[k] <= '0;
      else if (upd[k]) attr_q[k] <= new_val;
    assign bus.attr_o[k*AttrDw +: AttrDw] = upd[k] ? new_val : attr_q[k];
  end
  assign bus.attr_update_o = upd;
  assign bus.req_ready_o   = rdy_q;
  assign bus.rsp_valid_o   = state == RESP;
  assign bus.rsp_err_o     = (state == RESP) & err_q;
  assign bus.rsp_attr_o    = (state == RESP && !err_q) ? rsp_q : '0;
endmodule
